tiled_conv_mac_sched: RTL and testbench

- Sequences one shared 4-stage pipelined 16x16 signed multiplier (29-bit product, 4-cycle latency, ce-gated) across NUM_REQ requesters in the tiled convolution engine.
- Grants the multiplier round-robin, tracks in-flight operations in a shift register aligned to the multiplier latency, and returns each product to its originator with a valid pulse.
- Drives the multiplier's ce; freezes the pipeline when any returning product's destination is not ready.

---
 rtl/tiled_conv_mac_sched_pkg.sv | 25 ++
 rtl/tiled_conv_rr_arb.sv | 51 +++++
 rtl/tiled_conv_mac_sched.sv | 119 +++++++++++
 tb/tb_tiled_conv_mac_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiled_conv_mac_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tiled_conv_sched_pkg
//  Purpose  : Shared constants and the in-flight tag type for the tiled
//             convolution multiplier scheduler.
//  Contents : DW, PW, MUL_LAT defaults; ID_W tag index width; tag_t.
//  Revision : 1.0 - initial release
// ============================================================================
package tiled_conv_sched_pkg;

  localparam int DW      = 16;  // signed operand width
  localparam int PW      = 29;  // signed product width seen on mul_dout
  localparam int MUL_LAT = 4;   // multiplier latency in ce-enabled cycles

  // Sized for the largest supported requester count (8), so a single tag
  // layout serves every legal NUM_REQ.
  localparam int ID_W = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/tiled_conv_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tiled_conv_rr_arb
//  Purpose  : Combinational round-robin arbiter. Picks the first set request
//             starting at ptr and searching upward with wrap-around.
//  Ports    : req    - request vector
//             ptr    - index that has highest priority this cycle (< NUM_REQ)
//             en     - when low no grant is issued
//             grant  - one-hot grant (all zero when nothing is granted)
//             winner - index of the granted requester (0 when none)
//  Revision : 1.0 - initial release
// ============================================================================
module tiled_conv_rr_arb #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      winner
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr and k are both below NUM_REQ, so one conditional subtract
      // is enough to wrap the candidate index.
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      idx = sum[IW-1:0];
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tiled_conv_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tiled_conv_mac_sched
//  Purpose  : Shares one pipelined signed multiplier among NUM_REQ requesters.
//             Grants round-robin, tracks each operation with a tag that moves
//             in lock-step with the multiplier pipeline, and returns every
//             product to its originator with a one-hot valid. A product whose
//             sink is not ready freezes the whole pipeline through mul_ce.
//  Ports    : ap_clk, ap_rst        - clock, synchronous active-high reset
//             req_valid/a/b/ready   - per-requester operand handshake
//             rsp_valid/ready, rsp_p- per-requester product handshake
//             mul_ce, mul_din0/1    - drive the external multiplier
//             mul_dout              - product from the external multiplier
//             busy                  - any operation in flight
//  Revision : 1.0 - initial release
// ============================================================================
module tiled_conv_mac_sched
  import tiled_conv_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = tiled_conv_sched_pkg::MUL_LAT,
  parameter int DW      = tiled_conv_sched_pkg::DW,
  parameter int PW      = tiled_conv_sched_pkg::PW
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [PW-1:0]         rsp_p,
  output logic                  mul_ce,
  output logic [DW-1:0]         mul_din0,
  output logic [DW-1:0]         mul_din1,
  input  logic [PW-1:0]         mul_dout,
  output logic                  busy
);

  localparam int IW = $clog2(NUM_REQ);

  // Stage 0 is loaded on the accept edge together with the multiplier input
  // register; stage MUL_LAT therefore lines up with mul_dout.
  tag_t [MUL_LAT:0]   tag_pipe;
  tag_t               out_tag;
  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      winner;
  logic               grant_any;
  logic               issue_en;
  logic               stall;
  logic               any_valid;
  logic [NUM_REQ-1:0] out_hit;

  assign out_tag = tag_pipe[MUL_LAT];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hit
    assign out_hit[i] = out_tag.valid && (out_tag.id == ID_W'(i));
  end

  // Freeze only when the product at the output has a destination that is
  // not ready. During reset ce is forced on so stale products drain out.
  assign stall    = |(out_hit & ~rsp_ready);
  assign mul_ce   = ap_rst | ~stall;
  assign issue_en = mul_ce & ~ap_rst;

  tiled_conv_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .en     (issue_en),
    .grant  (grant),
    .winner (winner)
  );

  assign grant_any = |grant;
  assign req_ready = grant;

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mul_din0 = req_a[i*DW +: DW];
        mul_din1 = req_b[i*DW +: DW];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int s = 0; s <= MUL_LAT; s++) begin
      any_valid = any_valid | tag_pipe[s].valid;
    end
  end

  assign rsp_valid = ap_rst ? '0 : out_hit;
  assign rsp_p     = mul_dout;
  assign busy      = ~ap_rst & any_valid;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      tag_pipe <= '0;
      rr_ptr   <= '0;
    end else if (mul_ce) begin
      tag_pipe[0] <= {grant_any, ID_W'(winner)};
      for (int s = 1; s <= MUL_LAT; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
      if (grant_any) begin
        rr_ptr <= (winner == IW'(NUM_REQ-1)) ? '0 : winner + IW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tiled_conv_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tiled_conv_mac_sched
//  Purpose  : Self-checking bench for tiled_conv_mac_sched. Includes a
//             ce-gated pipelined multiplier model (input register plus
//             MUL_LAT stages) and a queue-based reference of in-flight ops.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tiled_conv_mac_sched;

  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 4;
  localparam int DW      = 16;
  localparam int PW      = 29;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst;
  logic [NUM_REQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*DW-1:0] req_a, req_b;
  logic [PW-1:0]         rsp_p, mul_dout;
  logic                  mul_ce, busy;
  logic [DW-1:0]         mul_din0, mul_din1;

  always #5 ap_clk = ~ap_clk;

  tiled_conv_mac_sched #(
    .NUM_REQ (NUM_REQ), .MUL_LAT (MUL_LAT), .DW (DW), .PW (PW)
  ) dut (
    .ap_clk (ap_clk), .ap_rst (ap_rst),
    .req_valid (req_valid), .req_a (req_a), .req_b (req_b), .req_ready (req_ready),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_p (rsp_p),
    .mul_ce (mul_ce), .mul_din0 (mul_din0), .mul_din1 (mul_din1),
    .mul_dout (mul_dout), .busy (busy)
  );

  // Multiplier: operands captured on an enabled edge show up on dout
  // MUL_LAT+1 enabled edges later; the port keeps the low PW bits.
  logic signed [31:0] mul_full;
  logic [PW-1:0]      mul_pipe [0:MUL_LAT];
  assign mul_full = $signed(mul_din0) * $signed(mul_din1);
  assign mul_dout = mul_pipe[MUL_LAT];
  always_ff @(posedge ap_clk) begin
    if (mul_ce) begin
      mul_pipe[0] <= mul_full[PW-1:0];
      for (int k = 1; k <= MUL_LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
    end
  end

  // Stimulus
  logic                  drv_rst;
  logic [NUM_REQ-1:0]    drv_valid, drv_rready;
  logic signed [DW-1:0]  drv_a [NUM_REQ];
  logic signed [DW-1:0]  drv_b [NUM_REQ];

  // Reference: ops in issue order with the number of enabled edges since accept
  int            q_id[$];
  int            q_age[$];
  logic [PW-1:0] q_p[$];
  int            m_ptr;

  logic [NUM_REQ-1:0] exp_ready, exp_rv, obs_ready, obs_rv;
  logic [PW-1:0]      exp_p, obs_p;
  logic               exp_ce, exp_busy, obs_ce, obs_busy;

  int checks = 0;
  int passed = 0;

  function automatic logic [PW-1:0] mul_ref(input int a, input int b);
    int full;
    full = a * b;
    return full[PW-1:0];
  endfunction

  task automatic tick();
    int g;
    int r;
    @(negedge ap_clk);
    ap_rst    = drv_rst;
    req_valid = drv_valid;
    rsp_ready = drv_rready;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*DW +: DW] = drv_a[i];
      req_b[i*DW +: DW] = drv_b[i];
    end
    #1;
    exp_rv = '0; exp_p = '0; exp_ready = '0; exp_ce = 1'b1; exp_busy = 1'b0; g = -1;
    if (!drv_rst) begin
      exp_busy = (q_id.size() != 0);
      if (q_id.size() != 0 && q_age[0] == MUL_LAT) begin
        exp_rv[q_id[0]] = 1'b1;
        exp_p  = q_p[0];
        exp_ce = drv_rready[q_id[0]];
      end
      if (exp_ce) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          r = (m_ptr + k) % NUM_REQ;
          if (g < 0 && drv_valid[r]) g = r;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    obs_ready = req_ready; obs_rv = rsp_valid; obs_p = rsp_p;
    obs_ce = mul_ce; obs_busy = busy;
    @(posedge ap_clk);
    if (drv_rst) begin
      q_id.delete(); q_age.delete(); q_p.delete(); m_ptr = 0;
    end else if (exp_ce) begin
      if (exp_rv != '0) begin
        void'(q_id.pop_front()); void'(q_age.pop_front()); void'(q_p.pop_front());
      end
      for (int j = 0; j < q_age.size(); j++) q_age[j] = q_age[j] + 1;
      if (g >= 0) begin
        q_id.push_back(g);
        q_age.push_back(0);
        q_p.push_back(mul_ref(int'(drv_a[g]), int'(drv_b[g])));
        m_ptr = (g + 1) % NUM_REQ;
      end
    end
  endtask

  task automatic idle_inputs();
    drv_rst = 1'b0; drv_valid = '0; drv_rready = '1;
    for (int i = 0; i < NUM_REQ; i++) begin drv_a[i] = '0; drv_b[i] = '0; end
  endtask

  task automatic do_reset();
    idle_inputs();
    drv_rst = 1'b1;
    tick(); tick();
    drv_rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    drv_rst = 1'b1; drv_valid = '1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs_ready !== '0 || obs_rv !== '0 || obs_ce !== 1'b1 || obs_busy !== 1'b0)
        $display("FAIL reset c%0d got rdy=%b rv=%b ce=%b busy=%b want 0000 0000 1 0", c, obs_ready, obs_rv, obs_ce, obs_busy);
      else passed++;
    end
    drv_rst = 1'b0; drv_valid = '0;
    tick();
    checks++;
    if (obs_busy !== 1'b0 || obs_rv !== '0 || obs_ce !== 1'b1)
      $display("FAIL reset_release got rv=%b ce=%b busy=%b want 0000 1 0", obs_rv, obs_ce, obs_busy);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    drv_valid = 4'b0010; drv_a[1] = 16'sd3; drv_b[1] = -16'sd7;
    for (int c = 0; c < 9; c++) begin
      tick();
      drv_valid = '0;
      checks++;
      if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_ce !== exp_ce || obs_busy !== exp_busy || (exp_rv != '0 && obs_p !== exp_p))
        $display("FAIL single c%0d got rdy=%b rv=%b ce=%b busy=%b p=%0d want rdy=%b rv=%b ce=%b busy=%b p=%0d", c, obs_ready, obs_rv, obs_ce, obs_busy, obs_p, exp_ready, exp_rv, exp_ce, exp_busy, exp_p);
      else passed++;
      checks++;
      if (obs_busy !== (c >= 1 && c <= 5))
        $display("FAIL single_busy c%0d got %b want %b", c, obs_busy, (c >= 1 && c <= 5));
      else passed++;
      if (c == 5) begin
        checks++;
        if (obs_rv !== 4'b0010 || obs_p !== PW'(-21))
          $display("FAIL single_result got rv=%b p=%h want rv=0010 p=%h", obs_rv, obs_p, PW'(-21));
        else passed++;
      end
    end
  endtask

  task automatic test_fairness();
    int cnt [NUM_REQ];
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
    for (int c = 0; c < 20; c++) begin
      drv_valid = (c < 8) ? 4'hF : 4'h0;
      for (int i = 0; i < NUM_REQ; i++) begin drv_a[i] = DW'($urandom); drv_b[i] = DW'($urandom); end
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_ce !== exp_ce || obs_busy !== exp_busy || (exp_rv != '0 && obs_p !== exp_p))
        $display("FAIL fair c%0d got rdy=%b rv=%b ce=%b busy=%b p=%0d want rdy=%b rv=%b ce=%b busy=%b p=%0d", c, obs_ready, obs_rv, obs_ce, obs_busy, obs_p, exp_ready, exp_rv, exp_ce, exp_busy, exp_p);
      else passed++;
      if (c < 8) begin
        checks++;
        if (obs_ready !== 4'(1 << (c % 4)))
          $display("FAIL fair_order c%0d got %b want %b", c, obs_ready, 4'(1 << (c % 4)));
        else passed++;
      end
      for (int i = 0; i < NUM_REQ; i++) if (obs_rv[i]) cnt[i]++;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      checks++;
      if (cnt[i] != 2) $display("FAIL fair_count req%0d got %0d want 2", i, cnt[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int n_del;
    int last_c;
    logic [PW-1:0] prev_p;
    do_reset();
    n_del = 0; last_c = -1; prev_p = '0;
    for (int c = 0; c < 22; c++) begin
      drv_valid  = (c <= 12) ? 4'b0100 : 4'b0000;
      drv_a[2]   = DW'($urandom); drv_b[2] = DW'($urandom);
      drv_rready = (c >= 6 && c <= 8) ? 4'b1011 : 4'b1111;
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_ce !== exp_ce || obs_busy !== exp_busy || (exp_rv != '0 && obs_p !== exp_p))
        $display("FAIL bp c%0d got rdy=%b rv=%b ce=%b busy=%b p=%0d want rdy=%b rv=%b ce=%b busy=%b p=%0d", c, obs_ready, obs_rv, obs_ce, obs_busy, obs_p, exp_ready, exp_rv, exp_ce, exp_busy, exp_p);
      else passed++;
      if (c >= 6 && c <= 8) begin
        checks++;
        if (obs_ce !== 1'b0 || obs_ready !== '0 || obs_rv !== 4'b0100)
          $display("FAIL bp_stall c%0d got ce=%b rdy=%b rv=%b want 0 0000 0100", c, obs_ce, obs_ready, obs_rv);
        else passed++;
      end
      if (c >= 7 && c <= 9) begin
        checks++;
        if (obs_p !== prev_p) $display("FAIL bp_hold c%0d got p=%h want %h", c, obs_p, prev_p);
        else passed++;
      end
      prev_p = obs_p;
      if (obs_rv[2] && drv_rready[2]) begin n_del++; last_c = c; end
    end
    checks++;
    if (n_del != 10 || last_c != 17)
      $display("FAIL bp_total got n=%0d last=%0d want n=10 last=17", n_del, last_c);
    else passed++;
  endtask

  task automatic test_extremes();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drv_valid = (c < 3) ? 4'b1000 : 4'b0000;
      case (c)
        0: begin drv_a[3] = -16'sd32768; drv_b[3] = 16'sd32767; end
        1: begin drv_a[3] = 16'sd0;      drv_b[3] = DW'($urandom); end
        default: begin drv_a[3] = -16'sd32768; drv_b[3] = -16'sd32768; end
      endcase
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_ce !== exp_ce || obs_busy !== exp_busy || (exp_rv != '0 && obs_p !== exp_p))
        $display("FAIL ext c%0d got rdy=%b rv=%b ce=%b busy=%b p=%0d want rdy=%b rv=%b ce=%b busy=%b p=%0d", c, obs_ready, obs_rv, obs_ce, obs_busy, obs_p, exp_ready, exp_rv, exp_ce, exp_busy, exp_p);
      else passed++;
      // The product port keeps only the low PW bits of the full result.
      if (c == 5) begin
        checks++;
        if (obs_rv !== 4'b1000 || obs_p !== PW'(-1073709056))
          $display("FAIL ext_minmax got rv=%b p=%h want 1000 %h", obs_rv, obs_p, PW'(-1073709056));
        else passed++;
      end
      if (c == 6) begin
        checks++;
        if (obs_rv !== 4'b1000 || obs_p !== '0)
          $display("FAIL ext_zero got rv=%b p=%h want 1000 0", obs_rv, obs_p);
        else passed++;
      end
      if (c == 7) begin
        checks++;
        if (obs_rv !== 4'b1000 || obs_p !== PW'(1073741824))
          $display("FAIL ext_minmin got rv=%b p=%h want 1000 %h", obs_rv, obs_p, PW'(1073741824));
        else passed++;
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic signed [DW-1:0] fa, fb;
    do_reset();
    fa = DW'($urandom); fb = DW'($urandom);
    for (int c = 0; c < 17; c++) begin
      drv_valid = '0; drv_rst = 1'b0;
      if (c < 3) drv_valid = 4'(1 << c);
      if (c == 2) drv_rst = 1'b1;
      if (c == 10) begin drv_valid = 4'b0010; drv_a[1] = fa; drv_b[1] = fb; end
      else for (int i = 0; i < NUM_REQ; i++) begin drv_a[i] = DW'($urandom); drv_b[i] = DW'($urandom); end
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_ce !== exp_ce || obs_busy !== exp_busy || (exp_rv != '0 && obs_p !== exp_p))
        $display("FAIL midrst c%0d got rdy=%b rv=%b ce=%b busy=%b p=%0d want rdy=%b rv=%b ce=%b busy=%b p=%0d", c, obs_ready, obs_rv, obs_ce, obs_busy, obs_p, exp_ready, exp_rv, exp_ce, exp_busy, exp_p);
      else passed++;
      if (c >= 2 && c <= 14) begin
        checks++;
        if (obs_rv !== '0) $display("FAIL midrst_stale c%0d got rv=%b want 0000", c, obs_rv);
        else passed++;
      end
      if (c == 3) begin
        checks++;
        if (obs_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", obs_busy);
        else passed++;
      end
      if (c == 15) begin
        checks++;
        if (obs_rv !== 4'b0010 || obs_p !== mul_ref(int'(fa), int'(fb)))
          $display("FAIL midrst_fresh got rv=%b p=%h want 0010 %h", obs_rv, obs_p, mul_ref(int'(fa), int'(fb)));
        else passed++;
      end
    end
    drv_rst = 1'b0;
  endtask

  task automatic test_bubbles();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drv_valid = (c < 10 && c % 2 == 0) ? 4'b0001 : 4'b0000;
      drv_a[0] = DW'($urandom); drv_b[0] = DW'($urandom);
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_ce !== exp_ce || obs_busy !== exp_busy || (exp_rv != '0 && obs_p !== exp_p))
        $display("FAIL bubble c%0d got rdy=%b rv=%b ce=%b busy=%b p=%0d want rdy=%b rv=%b ce=%b busy=%b p=%0d", c, obs_ready, obs_rv, obs_ce, obs_busy, obs_p, exp_ready, exp_rv, exp_ce, exp_busy, exp_p);
      else passed++;
      checks++;
      if (obs_ce !== 1'b1 || obs_rv[0] !== (c >= 5 && c < 15 && (c - 5) % 2 == 0))
        $display("FAIL bubble_pattern c%0d got ce=%b rv0=%b want 1 %b", c, obs_ce, obs_rv[0], (c >= 5 && c < 15 && (c - 5) % 2 == 0));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 140; c++) begin
      drv_valid  = (c < 120) ? NUM_REQ'($urandom) : '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        drv_a[i] = DW'($urandom); drv_b[i] = DW'($urandom);
        drv_rready[i] = (c >= 120) || ($urandom_range(3) != 0);
      end
      tick();
      checks++;
      if (obs_ready !== exp_ready || obs_rv !== exp_rv || obs_ce !== exp_ce || obs_busy !== exp_busy || (exp_rv != '0 && obs_p !== exp_p))
        $display("FAIL b2b c%0d got rdy=%b rv=%b ce=%b busy=%b p=%0d want rdy=%b rv=%b ce=%b busy=%b p=%0d", c, obs_ready, obs_rv, obs_ce, obs_busy, obs_p, exp_ready, exp_rv, exp_ce, exp_busy, exp_p);
      else passed++;
    end
    checks++;
    if (obs_busy !== 1'b0 || q_id.size() != 0)
      $display("FAIL b2b_drain got busy=%b left=%0d want 0 0", obs_busy, q_id.size());
    else passed++;
  endtask

  initial begin
    ap_rst = 1'b1; req_valid = '0; rsp_ready = '1; req_a = '0; req_b = '0;
    m_ptr = 0;
    idle_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_extremes();
    test_reset_midflight();
    test_bubbles();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
